// File: rtl/clk_hs_pkg.sv
// Shared types for the multi-channel clock-request handshake.
// State codes give req (bit 1) and active (bit 2) their own flop bits.
package clk_hs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_REQ     = 3'b011,
    ST_ACTIVE  = 3'b111,
    ST_RELEASE = 3'b100,
    ST_ERR     = 3'b001
  } state_e;

  // Watchdog counter width; at least one bit so a disabled watchdog still elaborates.
  function automatic int unsigned cnt_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/clk_hs_ch.sv
// One handshake channel: optional ack synchroniser, four-phase FSM and
// watchdog with a sticky timeout flag.
module clk_hs_ch
  import clk_hs_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES    = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_lp_clk_ack,
  input  logic i_err_clr,
  output logic o_pl_clk_req,
  output logic o_awake,
  output logic o_timeout_err
);

  localparam int unsigned CNT_W = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

  logic             ack_s;
  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             timeout_c;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ack_s = i_lp_clk_ack;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= '0;
        else          sync_q <= (sync_q << 1) | SYNC_STAGES'(i_lp_clk_ack);
      end
      assign ack_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_n;
  end

  // Exit conditions are tested before the watchdog so a coincident ack wins.
  always_comb begin
    state_n   = state_q;
    timeout_c = WDOG_EN && (cnt_q == CNT_LAST);
    case (state_q)
      ST_IDLE:    if (i_en) state_n = ST_REQ;
      ST_REQ: begin
        if (ack_s)          state_n = ST_ACTIVE;
        else if (timeout_c) state_n = ST_ERR;
      end
      ST_ACTIVE:  if (!i_en) state_n = ST_RELEASE;
      ST_RELEASE: begin
        if (!ack_s)         state_n = ST_IDLE;
        else if (timeout_c) state_n = ST_ERR;
      end
      ST_ERR:     if (i_err_clr && !ack_s) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Dwell counter: restarts on any state change, saturates instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (state_n != state_q) begin
      cnt_q <= '0;
    end else if ((state_q == ST_REQ || state_q == ST_RELEASE) && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= (state_n == ST_ERR);
  end

  assign o_pl_clk_req  = state_q[1];
  assign o_awake       = state_q[2] & state_q[1];
  assign o_timeout_err = err_q;

endmodule

// File: rtl/clk_handshake_mc.sv
// Multi-channel RDI clock-request handshake: NUM_CH independent channels
// plus an all-channels-awake summary.
module clk_handshake_mc
  import clk_hs_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_en,
  input  logic [NUM_CH-1:0] i_lp_clk_ack,
  input  logic [NUM_CH-1:0] i_err_clr,
  output logic [NUM_CH-1:0] o_pl_clk_req,
  output logic [NUM_CH-1:0] o_adapter_is_waked_up,
  output logic [NUM_CH-1:0] o_timeout_err,
  output logic              o_all_awake
);

  logic [NUM_CH-1:0] awake;

  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_ch
    clk_hs_ch #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_ch (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_en         (i_en[g]),
      .i_lp_clk_ack (i_lp_clk_ack[g]),
      .i_err_clr    (i_err_clr[g]),
      .o_pl_clk_req (o_pl_clk_req[g]),
      .o_awake      (awake[g]),
      .o_timeout_err(o_timeout_err[g])
    );
  end

  assign o_adapter_is_waked_up = awake;
  assign o_all_awake           = &awake;

endmodule
